// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: (J,K) mode encodings and the excitation
// function that maps a present/next bit pair onto the J/K inputs.
package jk_pkg;

    // Encoded as {J,K}; the enum order lines up with the binary value.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    // Excitation that only ever uses hold/set/reset, never toggle.
    function automatic logic [1:0] jk_excite(input logic q, input logic n);
        return {~q & n, q & ~n};
    endfunction

endpackage

// File: rtl/jk_ff_rn.sv
// Single JK flip-flop cell with asynchronous active-low reset.
module jk_ff_rn
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic J,
    input  logic K,
    output logic q
);

    jk_mode_e mode;

    assign mode = jk_mode_e'({J, K});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (mode)
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MOD up/down counter whose state bits are JK flip-flops; the J/K
// inputs are derived from a conventional next-state mux.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               CLAMP = (MOD < (1 << WIDTH));

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_n;

    // With a full binary modulus every d is already legal, so no clamp exists.
    generate
        if (CLAMP) begin : g_clamp
            assign load_val = (d > LAST) ? LAST : d;
        end else begin : g_noclamp
            assign load_val = d;
        end
    endgenerate

    always_comb begin
        n      = q;
        wrap_n = 1'b0;
        if (load) begin
            n = load_val;
        end else if (en) begin
            if (up) begin
                if (q == LAST) begin
                    n      = '0;
                    wrap_n = 1'b1;
                end else begin
                    n = q + ONE;
                end
            end else begin
                if (q == '0) begin
                    n      = LAST;
                    wrap_n = 1'b1;
                end else begin
                    n = q - ONE;
                end
            end
        end
    end

    assign tc = en & ~load & ((up & (q == LAST)) | (~up & (q == '0)));

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign {j[i], k[i]} = jk_excite(q[i], n[i]);

            jk_ff_rn u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .J     (j[i]),
                .K     (k[i]),
                .q     (q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_n;
        end
    end

endmodule
